// File: rtl/cpcs_8b10b_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpcs_8b10b_pkg
// Brief    : 8b/10b code tables, K-code constants and lane classifier record.
// Revision : 1.0 - initial release
// ============================================================================
package cpcs_8b10b_pkg;

    localparam int BYTE_W = 8;
    localparam int SYM_W  = 10;
    localparam int C6_W   = 6;
    localparam int C4_W   = 4;

    localparam logic [C4_W-1:0] C4_A7_NEG = 4'b0111;

    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_1 = 8'h3C;
    localparam logic [7:0] K28_2 = 8'h5C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_4 = 8'h9C;
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_6 = 8'hDC;
    localparam logic [7:0] K28_7 = 8'hFC;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K30_7 = 8'hFE;

    // Codes are held as {a,b,c,d,e,i} / {f,g,h,j}, RD- column.
    typedef struct packed {
        logic [C6_W-1:0] c6;
        logic            flag6;
        logic            flag_d7;
        logic [C4_W-1:0] c4;
        logic            flag4;
        logic            comp4;
        logic            is_y7;
        logic            k_alt7;
        logic            a7_neg;
        logic            a7_pos;
        logic            kerr;
    } lane_cls_t;

    function automatic logic [C6_W-1:0] enc6_neg(input logic [4:0] x);
        logic [C6_W-1:0] c;
        case (x)
            5'd0:    c = 6'b100111;
            5'd1:    c = 6'b011101;
            5'd2:    c = 6'b101101;
            5'd3:    c = 6'b110001;
            5'd4:    c = 6'b110101;
            5'd5:    c = 6'b101001;
            5'd6:    c = 6'b011001;
            5'd7:    c = 6'b111000;
            5'd8:    c = 6'b111001;
            5'd9:    c = 6'b100101;
            5'd10:   c = 6'b010101;
            5'd11:   c = 6'b110100;
            5'd12:   c = 6'b001101;
            5'd13:   c = 6'b101100;
            5'd14:   c = 6'b011100;
            5'd15:   c = 6'b010111;
            5'd16:   c = 6'b011011;
            5'd17:   c = 6'b100011;
            5'd18:   c = 6'b010011;
            5'd19:   c = 6'b110010;
            5'd20:   c = 6'b001011;
            5'd21:   c = 6'b101010;
            5'd22:   c = 6'b011010;
            5'd23:   c = 6'b111010;
            5'd24:   c = 6'b110011;
            5'd25:   c = 6'b100110;
            5'd26:   c = 6'b010110;
            5'd27:   c = 6'b110110;
            5'd28:   c = 6'b001110;
            5'd29:   c = 6'b101110;
            5'd30:   c = 6'b011110;
            default: c = 6'b101011;
        endcase
        return c;
    endfunction

    function automatic logic neutral6(input logic [4:0] x);
        return !(x inside {5'd0, 5'd1, 5'd2, 5'd4, 5'd8, 5'd15, 5'd16,
                           5'd23, 5'd24, 5'd27, 5'd29, 5'd30, 5'd31});
    endfunction

    function automatic logic [C4_W-1:0] enc4_neg(input logic [2:0] y);
        logic [C4_W-1:0] c;
        case (y)
            3'd0:    c = 4'b1011;
            3'd1:    c = 4'b1001;
            3'd2:    c = 4'b0101;
            3'd3:    c = 4'b1100;
            3'd4:    c = 4'b1101;
            3'd5:    c = 4'b1010;
            3'd6:    c = 4'b0110;
            default: c = 4'b1110;
        endcase
        return c;
    endfunction

    // K28.y: balanced codes .1/.2/.5/.6 are the complement of the data code.
    function automatic logic [C4_W-1:0] k28_enc4_neg(input logic [2:0] y);
        logic [C4_W-1:0] c;
        case (y)
            3'd0:    c = 4'b1011;
            3'd1:    c = 4'b0110;
            3'd2:    c = 4'b1010;
            3'd3:    c = 4'b1100;
            3'd4:    c = 4'b1101;
            3'd5:    c = 4'b0101;
            3'd6:    c = 4'b1001;
            default: c = 4'b0111;
        endcase
        return c;
    endfunction

    function automatic logic neutral4(input logic [2:0] y);
        return !(y inside {3'd0, 3'd4, 3'd7});
    endfunction

    function automatic logic alt7_neg(input logic [4:0] x);
        return x inside {5'd17, 5'd18, 5'd20};
    endfunction

    function automatic logic alt7_pos(input logic [4:0] x);
        return x inside {5'd11, 5'd13, 5'd14};
    endfunction

    function automatic logic k_valid(input logic [7:0] b);
        return b inside {K28_0, K28_1, K28_2, K28_3, K28_4, K28_5, K28_6, K28_7,
                         K23_7, K27_7, K29_7, K30_7};
    endfunction

    // Reorders {abcdei,fghj} into line order with a at bit 0.
    function automatic logic [SYM_W-1:0] to_line(input logic [C6_W-1:0] c6,
                                                  input logic [C4_W-1:0] c4);
        logic [SYM_W-1:0] s;
        logic [SYM_W-1:0] r;
        s = {c6, c4};
        for (int i = 0; i < SYM_W; i++) begin
            r[i] = s[SYM_W-1-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpcs_enc_8b10b_nlane_if.sv
`default_nettype none
// ============================================================================
// Module   : cpcs_enc_8b10b_nlane_if
// Brief    : TX byte/control bundle into the encoder and coded symbols out.
// Revision : 1.0 - initial release
// ============================================================================
interface cpcs_enc_8b10b_nlane_if #(
    parameter int NUM_LANES = 2
);
    logic                      ENABLE;
    logic                      DIN_VALID;
    logic [8*NUM_LANES-1:0]    DIN;
    logic [NUM_LANES-1:0]      KIN;
    logic                      FORCE_RD_EN;
    logic                      FORCE_RD_VAL;
    logic [10*NUM_LANES-1:0]   DOUT;
    logic                      DOUT_VALID;
    logic [NUM_LANES-1:0]      KERR;
    logic                      RD_OUT;

    modport master (
        output ENABLE, DIN_VALID, DIN, KIN, FORCE_RD_EN, FORCE_RD_VAL,
        input  DOUT, DOUT_VALID, KERR, RD_OUT
    );

    modport slave (
        input  ENABLE, DIN_VALID, DIN, KIN, FORCE_RD_EN, FORCE_RD_VAL,
        output DOUT, DOUT_VALID, KERR, RD_OUT
    );
endinterface
`default_nettype wire

// File: rtl/cpcs_enc_lane_cls.sv
`default_nettype none
// ============================================================================
// Module   : cpcs_enc_lane_cls
// Brief    : Stage-1 classifier: RD- codes and disparity flags for one byte.
// Revision : 1.0 - initial release
// ============================================================================
module cpcs_enc_lane_cls
    import cpcs_8b10b_pkg::*;
(
    input  wire logic              CLK,
    input  wire logic              aresetn,
    input  wire logic              enable,
    input  wire logic [BYTE_W-1:0] din,
    input  wire logic              kin,
    output lane_cls_t              cls
);

    logic [4:0] x;
    logic [2:0] y;
    logic       k_ok;
    logic       k28;
    lane_cls_t  cls_next;

    assign x    = din[4:0];
    assign y    = din[7:5];
    assign k_ok = kin && k_valid(din);
    assign k28  = k_ok && (x == 5'd28);

    // An unsupported K byte falls through to its data code with kerr set.
    always_comb begin
        cls_next         = '0;
        cls_next.c6      = k28 ? 6'b001111 : enc6_neg(x);
        cls_next.flag6   = k28 ? 1'b1 : !neutral6(x);
        cls_next.flag_d7 = (x == 5'd7);
        cls_next.c4      = k28 ? k28_enc4_neg(y) : enc4_neg(y);
        cls_next.flag4   = !neutral4(y);
        cls_next.comp4   = k28 || !neutral4(y) || (y == 3'd3);
        cls_next.is_y7   = (y == 3'd7);
        cls_next.k_alt7  = k_ok && (y == 3'd7);
        cls_next.a7_neg  = alt7_neg(x);
        cls_next.a7_pos  = alt7_pos(x);
        cls_next.kerr    = kin && !k_ok;
    end

    always_ff @(posedge CLK or negedge aresetn) begin
        if (!aresetn) begin
            cls <= '0;
        end else if (enable) begin
            cls <= cls_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpcs_enc_8b10b_nlane.sv
`default_nettype none
// ============================================================================
// Module   : cpcs_enc_8b10b_nlane
// Brief    : NUM_LANES-byte 8b/10b encoder, RD chained lane 0 -> N-1.
// Revision : 1.0 - initial release
// ============================================================================
module cpcs_enc_8b10b_nlane
    import cpcs_8b10b_pkg::*;
#(
    parameter int NUM_LANES = 2
)(
    input  wire logic              CLK,
    input  wire logic              aresetn,
    cpcs_enc_8b10b_nlane_if.slave  bus
);

    lane_cls_t                    cls [NUM_LANES];
    logic                         s1_valid;
    logic                         s1_force_en;
    logic                         s1_force_val;
    logic [SYM_W*NUM_LANES-1:0]   dout_reg;
    logic [SYM_W*NUM_LANES-1:0]   dout_next;
    logic [NUM_LANES-1:0]         kerr_reg;
    logic [NUM_LANES-1:0]         kerr_next;
    logic                         dout_valid_reg;
    logic                         rd_reg;
    logic                         rd_next;

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            cpcs_enc_lane_cls u_cls (
                .CLK     (CLK),
                .aresetn (aresetn),
                .enable  (bus.ENABLE),
                .din     (bus.DIN[g*BYTE_W +: BYTE_W]),
                .kin     (bus.KIN[g]),
                .cls     (cls[g])
            );
        end
    endgenerate

    always_ff @(posedge CLK or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid     <= 1'b0;
            s1_force_en  <= 1'b0;
            s1_force_val <= 1'b0;
        end else if (bus.ENABLE) begin
            s1_valid     <= bus.DIN_VALID;
            s1_force_en  <= bus.FORCE_RD_EN;
            s1_force_val <= bus.FORCE_RD_VAL;
        end
    end

    // rd_reg already holds the preceding word's result, so a force only
    // ever seeds the word it travelled with.
    always_comb begin
        logic            lane_rd;
        logic [C6_W-1:0] c6;
        logic [C4_W-1:0] c4;
        logic            use_a7;
        lane_rd   = s1_force_en ? s1_force_val : rd_reg;
        c6        = '0;
        c4        = '0;
        use_a7    = 1'b0;
        dout_next = '0;
        kerr_next = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            c6      = (lane_rd && (cls[i].flag6 || cls[i].flag_d7)) ? ~cls[i].c6 : cls[i].c6;
            lane_rd = lane_rd ^ cls[i].flag6;
            use_a7  = cls[i].is_y7 &&
                      (cls[i].k_alt7 || (lane_rd ? cls[i].a7_pos : cls[i].a7_neg));
            c4      = use_a7 ? C4_A7_NEG : cls[i].c4;
            c4      = (lane_rd && cls[i].comp4) ? ~c4 : c4;
            lane_rd = lane_rd ^ cls[i].flag4;
            dout_next[i*SYM_W +: SYM_W] = to_line(c6, c4);
            kerr_next[i] = cls[i].kerr;
        end
        rd_next = lane_rd;
    end

    always_ff @(posedge CLK or negedge aresetn) begin
        if (!aresetn) begin
            dout_reg       <= '0;
            kerr_reg       <= '0;
            dout_valid_reg <= 1'b0;
            rd_reg         <= 1'b0;
        end else if (bus.ENABLE) begin
            dout_valid_reg <= s1_valid;
            if (s1_valid) begin
                dout_reg <= dout_next;
                kerr_reg <= kerr_next;
                rd_reg   <= rd_next;
            end
        end
    end

    assign bus.DOUT       = dout_reg;
    assign bus.KERR       = kerr_reg;
    assign bus.DOUT_VALID = dout_valid_reg;
    assign bus.RD_OUT     = rd_reg;

endmodule
`default_nettype wire

// File: tb/tb_cpcs_enc_8b10b_nlane.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpcs_enc_8b10b_nlane
// Brief    : Directed-vector bench for the two-lane 8b/10b encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpcs_enc_8b10b_nlane;

    localparam int NL = 2;

    logic CLK = 1'b0;
    logic aresetn = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    cpcs_enc_8b10b_nlane_if #(.NUM_LANES(NL)) bus ();

    cpcs_enc_8b10b_nlane #(.NUM_LANES(NL)) dut (
        .CLK     (CLK),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [15:0] din, input logic [1:0] kin, input logic valid,
                         input logic fen, input logic fval);
        bus.DIN          = din;
        bus.KIN          = kin;
        bus.DIN_VALID    = valid;
        bus.FORCE_RD_EN  = fen;
        bus.FORCE_RD_VAL = fval;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        drive(16'hBCBC, 2'b11, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        vectors++; if (bus.DOUT !== 20'h0) begin miscompares++; $display("FAIL reset_dout: got %h expected %h", bus.DOUT, 20'h0); end
        vectors++; if (bus.DOUT_VALID !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", bus.DOUT_VALID); end
        vectors++; if (bus.KERR !== 2'b00) begin miscompares++; $display("FAIL reset_kerr: got %b expected 00", bus.KERR); end
        vectors++; if (bus.RD_OUT !== 1'b0) begin miscompares++; $display("FAIL reset_rd: got %b expected 0", bus.RD_OUT); end
        drive(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_data_basic();
        drive(16'hB500, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        drive(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        vectors++; if (bus.DOUT !== {10'h155, 10'h0B9}) begin miscompares++; $display("FAIL d0_dout: got %h expected %h", bus.DOUT, {10'h155, 10'h0B9}); end
        vectors++; if (bus.DOUT_VALID !== 1'b1) begin miscompares++; $display("FAIL d0_valid: got %b expected 1", bus.DOUT_VALID); end
        vectors++; if (bus.RD_OUT !== 1'b0) begin miscompares++; $display("FAIL d0_rd: got %b expected 0", bus.RD_OUT); end
        vectors++; if (bus.KERR !== 2'b00) begin miscompares++; $display("FAIL d0_kerr: got %b expected 00", bus.KERR); end
        tick();
        vectors++; if (bus.DOUT_VALID !== 1'b0) begin miscompares++; $display("FAIL idle_valid: got %b expected 0", bus.DOUT_VALID); end
        vectors++; if (bus.DOUT !== {10'h155, 10'h0B9}) begin miscompares++; $display("FAIL idle_hold: got %h expected %h", bus.DOUT, {10'h155, 10'h0B9}); end
    endtask

    task automatic test_k28_5();
        drive(16'hBCBC, 2'b11, 1'b1, 1'b0, 1'b0);
        tick();
        drive(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        vectors++; if (bus.DOUT !== {10'h283, 10'h17C}) begin miscompares++; $display("FAIL k285_dout: got %h expected %h", bus.DOUT, {10'h283, 10'h17C}); end
        vectors++; if (bus.RD_OUT !== 1'b0) begin miscompares++; $display("FAIL k285_rd: got %b expected 0", bus.RD_OUT); end
        vectors++; if (bus.KERR !== 2'b00) begin miscompares++; $display("FAIL k285_kerr: got %b expected 00", bus.KERR); end
    endtask

    task automatic test_alt7();
        drive(16'hB5F1, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        drive(16'hEBEB, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++; if (bus.DOUT !== {10'h155, 10'h3B1}) begin miscompares++; $display("FAIL a7neg_dout: got %h expected %h", bus.DOUT, {10'h155, 10'h3B1}); end
        vectors++; if (bus.RD_OUT !== 1'b1) begin miscompares++; $display("FAIL a7neg_rd: got %b expected 1", bus.RD_OUT); end
        drive(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        vectors++; if (bus.DOUT !== {10'h1CB, 10'h04B}) begin miscompares++; $display("FAIL a7pos_dout: got %h expected %h", bus.DOUT, {10'h1CB, 10'h04B}); end
        vectors++; if (bus.RD_OUT !== 1'b1) begin miscompares++; $display("FAIL a7pos_rd: got %b expected 1", bus.RD_OUT); end
    endtask

    task automatic test_kerr();
        drive(16'hB500, 2'b01, 1'b1, 1'b1, 1'b0);
        tick();
        drive(16'hBCF7, 2'b11, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++; if (bus.DOUT !== {10'h155, 10'h0B9}) begin miscompares++; $display("FAIL kerr_dout: got %h expected %h", bus.DOUT, {10'h155, 10'h0B9}); end
        vectors++; if (bus.KERR !== 2'b01) begin miscompares++; $display("FAIL kerr_flag: got %b expected 01", bus.KERR); end
        vectors++; if (bus.RD_OUT !== 1'b0) begin miscompares++; $display("FAIL kerr_rd: got %b expected 0", bus.RD_OUT); end
        drive(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        vectors++; if (bus.DOUT !== {10'h17C, 10'h057}) begin miscompares++; $display("FAIL k237_dout: got %h expected %h", bus.DOUT, {10'h17C, 10'h057}); end
        vectors++; if (bus.KERR !== 2'b00) begin miscompares++; $display("FAIL k237_kerr: got %b expected 00", bus.KERR); end
        vectors++; if (bus.RD_OUT !== 1'b1) begin miscompares++; $display("FAIL k237_rd: got %b expected 1", bus.RD_OUT); end
    endtask

    task automatic test_enable_stall();
        drive(16'hB5F1, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        drive(16'hF1B5, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++; if (bus.DOUT !== {10'h155, 10'h231}) begin miscompares++; $display("FAIL stall_a_dout: got %h expected %h", bus.DOUT, {10'h155, 10'h231}); end
        bus.ENABLE = 1'b0;
        drive(16'hBCBC, 2'b11, 1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++; if (bus.DOUT !== {10'h155, 10'h231}) begin miscompares++; $display("FAIL stall_hold_dout[%0d]: got %h expected %h", c, bus.DOUT, {10'h155, 10'h231}); end
            vectors++; if (bus.RD_OUT !== 1'b0) begin miscompares++; $display("FAIL stall_hold_rd[%0d]: got %b expected 0", c, bus.RD_OUT); end
            vectors++; if (bus.DOUT_VALID !== 1'b1) begin miscompares++; $display("FAIL stall_hold_valid[%0d]: got %b expected 1", c, bus.DOUT_VALID); end
        end
        bus.ENABLE = 1'b1;
        drive(16'h0000, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++; if (bus.DOUT !== {10'h3B1, 10'h155}) begin miscompares++; $display("FAIL stall_b_dout: got %h expected %h", bus.DOUT, {10'h3B1, 10'h155}); end
        vectors++; if (bus.RD_OUT !== 1'b1) begin miscompares++; $display("FAIL stall_b_rd: got %b expected 1", bus.RD_OUT); end
        drive(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        vectors++; if (bus.DOUT !== {10'h346, 10'h346}) begin miscompares++; $display("FAIL stall_c_dout: got %h expected %h", bus.DOUT, {10'h346, 10'h346}); end
        vectors++; if (bus.RD_OUT !== 1'b1) begin miscompares++; $display("FAIL stall_c_rd: got %b expected 1", bus.RD_OUT); end
        tick();
        vectors++; if (bus.DOUT_VALID !== 1'b0) begin miscompares++; $display("FAIL stall_tail_valid: got %b expected 0", bus.DOUT_VALID); end
    endtask

    task automatic test_force();
        drive(16'hB5F1, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        drive(16'hB5BC, 2'b01, 1'b1, 1'b1, 1'b1);
        tick();
        vectors++; if (bus.DOUT !== {10'h155, 10'h231}) begin miscompares++; $display("FAIL force_prev_dout: got %h expected %h", bus.DOUT, {10'h155, 10'h231}); end
        drive(16'hB500, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++; if (bus.DOUT !== {10'h155, 10'h283}) begin miscompares++; $display("FAIL force_dout: got %h expected %h", bus.DOUT, {10'h155, 10'h283}); end
        vectors++; if (bus.RD_OUT !== 1'b0) begin miscompares++; $display("FAIL force_rd: got %b expected 0", bus.RD_OUT); end
        drive(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        vectors++; if (bus.DOUT !== {10'h155, 10'h0B9}) begin miscompares++; $display("FAIL force_next_dout: got %h expected %h", bus.DOUT, {10'h155, 10'h0B9}); end
    endtask

    task automatic test_reset_midstream();
        drive(16'hB5F1, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        drive(16'hBCBC, 2'b11, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++; if (bus.RD_OUT !== 1'b1) begin miscompares++; $display("FAIL pre_reset_rd: got %b expected 1", bus.RD_OUT); end
        drive(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        vectors++; if (bus.DOUT !== 20'h0) begin miscompares++; $display("FAIL async_dout: got %h expected %h", bus.DOUT, 20'h0); end
        vectors++; if (bus.DOUT_VALID !== 1'b0) begin miscompares++; $display("FAIL async_valid: got %b expected 0", bus.DOUT_VALID); end
        vectors++; if (bus.RD_OUT !== 1'b0) begin miscompares++; $display("FAIL async_rd: got %b expected 0", bus.RD_OUT); end
        tick();
        aresetn = 1'b1;
        tick();
        vectors++; if (bus.DOUT_VALID !== 1'b0) begin miscompares++; $display("FAIL dropped_valid: got %b expected 0", bus.DOUT_VALID); end
        drive(16'hB500, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        drive(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        vectors++; if (bus.DOUT !== {10'h155, 10'h0B9}) begin miscompares++; $display("FAIL post_reset_dout: got %h expected %h", bus.DOUT, {10'h155, 10'h0B9}); end
        vectors++; if (bus.DOUT_VALID !== 1'b1) begin miscompares++; $display("FAIL post_reset_valid: got %b expected 1", bus.DOUT_VALID); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.ENABLE = 1'b1;
        drive(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_data_basic();
        test_k28_5();
        test_alt7();
        test_kerr();
        test_enable_stall();
        test_force();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
